// File: rtl/seq_det_ctrl.sv
// Word-level serial pattern detector: accepts a W-bit word, shifts it MSB-first past a
// programmable 4-bit pattern and reports the match count. OVERLAP_EN selects overlapping matches.
module seq_det_ctrl #(
    parameter int         W       = 16,
    parameter int         CNT_W   = 5,
    parameter logic [3:0] PAT_RST = 4'b1010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_pat,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_count,
    output logic             match_pulse,
    output logic             busy
);

    localparam int BC_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         pat_reg, pat_next;
    logic [W-1:0]       sreg_reg, sreg_next;
    logic [2:0]         hist_reg, hist_next;
    logic [2:0]         fill_reg, fill_next;
    logic [BC_W-1:0]    bitcnt_reg, bitcnt_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               pulse_reg, pulse_next;

    logic               bit_in;
    logic [3:0]         cand;
    logic               hit;

    // Only three history bits are stored: the oldest of four is never needed again.
    assign bit_in = sreg_reg[W-1];
    assign cand   = {hist_reg, bit_in};
    assign hit    = (fill_reg >= 3'd3) && (cand == pat_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pat_reg    <= PAT_RST;
            sreg_reg   <= '0;
            hist_reg   <= '0;
            fill_reg   <= '0;
            bitcnt_reg <= '0;
            count_reg  <= '0;
            pulse_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pat_reg    <= pat_next;
            sreg_reg   <= sreg_next;
            hist_reg   <= hist_next;
            fill_reg   <= fill_next;
            bitcnt_reg <= bitcnt_next;
            count_reg  <= count_next;
            pulse_reg  <= pulse_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pat_next    = pat_reg;
        sreg_next   = sreg_reg;
        hist_next   = hist_reg;
        fill_next   = fill_reg;
        bitcnt_next = bitcnt_reg;
        count_next  = count_reg;
        pulse_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // A pattern written on the accept edge already governs the accepted word.
                if (cfg_we) begin
                    pat_next = cfg_pat;
                end
                if (s_valid) begin
                    sreg_next   = s_data;
                    bitcnt_next = BC_W'(W);
                    count_next  = '0;
                    hist_next   = '0;
                    fill_next   = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                sreg_next   = sreg_reg << 1;
                hist_next   = cand[2:0];
                fill_next   = (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;
                bitcnt_next = bitcnt_reg - BC_W'(1);
                pulse_next  = hit;
                if (hit) begin
                    if (count_reg != {CNT_W{1'b1}}) begin
                        count_next = count_reg + CNT_W'(1);
                    end
`ifdef OVERLAP_EN
`else
                    hist_next = '0;
                    fill_next = '0;
`endif
                end
                if (bitcnt_reg == BC_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign s_ready     = (state_reg == IDLE);
    assign m_valid     = (state_reg == DONE);
    assign busy        = (state_reg == SHIFT);
    assign m_count     = count_reg;
    assign match_pulse = pulse_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed cases with literal expectations plus randomized traffic
// checked every cycle against a word-level reference model. Honours OVERLAP_EN.
module tb_seq_det_ctrl;

    localparam int W     = 16;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef OVERLAP_EN
    localparam int EXP_AAAA = 7;
    localparam int EXP_FFFF = 13;
`else
    localparam int EXP_AAAA = 4;
    localparam int EXP_FFFF = 4;
`endif

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             cfg_we  = 1'b0;
    logic [3:0]       cfg_pat = 4'b0000;
    logic             s_valid = 1'b0;
    logic [W-1:0]     s_data  = '0;
    logic             m_ready = 1'b0;
    logic             s_ready;
    logic             m_valid;
    logic [CNT_W-1:0] m_count;
    logic             match_pulse;
    logic             busy;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    seq_det_ctrl #(.W(W), .CNT_W(CNT_W), .PAT_RST(4'b1010)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count),
        .match_pulse(match_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Positions k (0 = first bit in time) at which a match completes, scanning left to right.
    function automatic logic [W-1:0] match_mask(input logic [W-1:0] w, input logic [3:0] p);
        logic [W-1:0] mask;
        logic [W-1:0] win;
        int k;
        mask = '0;
        k = 3;
        while (k < W) begin
            win = w >> (W - 1 - k);
            if (win[3:0] == p) begin
                mask[k] = 1'b1;
`ifdef OVERLAP_EN
                k = k + 1;
`else
                k = k + 4;
`endif
            end else begin
                k = k + 1;
            end
        end
        return mask;
    endfunction

    function automatic int hits_upto(input logic [W-1:0] mask, input int k);
        int c;
        c = 0;
        for (int i = 0; i <= k; i++) c += int'(mask[i]);
        return (c > CMAX) ? CMAX : c;
    endfunction

    // Reference model: phase 0 idle, 1 shifting (mk bits consumed), 2 result pending.
    int           mph   = 0;
    logic [3:0]   mpat  = 4'b1010;
    logic [W-1:0] mmask = '0;
    int           mk    = 0;
    int           mcnt  = 0;
    logic         mpulse = 1'b0;
    int           ntx   = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mph    <= 0;
            mpat   <= 4'b1010;
            mmask  <= '0;
            mk     <= 0;
            mcnt   <= 0;
            mpulse <= 1'b0;
        end else begin
            case (mph)
                0: begin
                    mpulse <= 1'b0;
                    if (cfg_we) mpat <= cfg_pat;
                    if (s_valid) begin
                        mmask <= match_mask(s_data, cfg_we ? cfg_pat : mpat);
                        mk    <= 0;
                        mcnt  <= 0;
                        mph   <= 1;
                    end
                end
                1: begin
                    mpulse <= mmask[mk];
                    mcnt   <= hits_upto(mmask, mk);
                    mk     <= mk + 1;
                    if (mk + 1 == W) mph <= 2;
                end
                default: begin
                    mpulse <= 1'b0;
                    if (m_ready) begin
                        $display("txn %0d: count %0d", ntx, mcnt);
                        ntx <= ntx + 1;
                        mph <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready",     int'(s_ready),     int'(mph == 0));
            check("busy",        int'(busy),        int'(mph == 1));
            check("m_valid",     int'(m_valid),     int'(mph == 2));
            check("m_count",     int'(m_count),     mcnt);
            check("match_pulse", int'(match_pulse), int'(mpulse));
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic run_word(input logic [W-1:0] w, input logic cfg, input logic [3:0] cp,
                            input logic mid_cfg, input int hold, input logic keep_valid,
                            output int cnt, output int lat, output int nbusy, output int npulse);
        int tries;
        cnt = 0; lat = 0; nbusy = 0; npulse = 0; tries = 0;
        s_data = w; s_valid = 1'b1; cfg_we = cfg; cfg_pat = cp;
        while (!s_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!s_ready) begin
            check("accept_timeout", 0, 1);
            s_valid = 1'b0; cfg_we = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0;
        while (lat < 40) begin
            nbusy  += int'(busy);
            npulse += int'(match_pulse);
            if (m_valid) break;
            if (mid_cfg && lat == 3) begin cfg_we = 1'b1; cfg_pat = 4'b0000; end
            if (lat == 4) cfg_we = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!m_valid) begin
            check("done_timeout", 0, 1);
            return;
        end
        cnt = int'(m_count);
        if (keep_valid) begin s_valid = 1'b1; s_data = 16'h00F0; end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_count", int'(m_count), cnt);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!m_valid && n < 40) begin @(negedge clk); n++; end
        check("wait_done_valid", int'(m_valid), 1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        int cnt, lat, nb, np;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_m_count", int'(m_count), 0);
        check("rst_match_pulse", int'(match_pulse), 0);
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_word(16'hAAAA, 1'b0, 4'b0000, 1'b0, 0, 1'b0, cnt, lat, nb, np);
        check("aaaa_count", cnt, EXP_AAAA);
        check("aaaa_pulses", np, EXP_AAAA);

        run_word(16'hFFFF, 1'b1, 4'b1111, 1'b0, 0, 1'b0, cnt, lat, nb, np);
        check("ffff_count", cnt, EXP_FFFF);
        check("ffff_pulses", np, EXP_FFFF);

        run_word(16'h0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0, cnt, lat, nb, np);
        check("zero_latency", lat, 16);
        check("zero_busy_cycles", nb, 16);
        check("zero_count", cnt, 0);

        run_word(16'hAAAA, 1'b1, 4'b1010, 1'b1, 0, 1'b0, cnt, lat, nb, np);
        check("midcfg_count", cnt, EXP_AAAA);
        run_word(16'hAAAA, 1'b0, 4'b0000, 1'b0, 0, 1'b0, cnt, lat, nb, np);
        check("pattern_kept_count", cnt, EXP_AAAA);

        run_word(16'h5A5A, 1'b0, 4'b0000, 1'b0, 5, 1'b1, cnt, lat, nb, np);
        check("gap_s_ready", int'(s_ready), 1);
        check("gap_m_valid", int'(m_valid), 0);
        @(negedge clk);
        s_valid = 1'b0;
        check("gap_accept_busy", int'(busy), 1);
        wait_done();

        s_data = 16'h6666; s_valid = 1'b1; cfg_we = 1'b1; cfg_pat = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_pulse", int'(match_pulse), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_s_ready", int'(s_ready), 1);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_count", int'(m_count), 0);
        check("midrst_match_pulse", int'(match_pulse), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_word(16'hAAAA, 1'b0, 4'b0000, 1'b0, 0, 1'b0, cnt, lat, nb, np);
        check("post_rst_pattern_count", cnt, EXP_AAAA);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: s_data = 16'hAAAA;
                1: s_data = 16'hFFFF;
                default: s_data = W'($urandom);
            endcase
            cfg_we = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: cfg_pat = 4'b1010;
                1: cfg_pat = 4'b1111;
                2: cfg_pat = 4'b0101;
                default: cfg_pat = 4'($urandom);
            endcase
            m_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_idle", int'(s_ready), 1);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
